regfile_onehot_wr: RTL

- 64-entry general-purpose register file for the single-cycle core.
- Consumes the one-hot 64-bit write-select word produced by the 6-to-64 write-address decoder directly upstream.
- Writes occur on the clock edge when enabled. Two combinational read ports feed the ALU operand muxes.
- Rejects malformed select words, i.e. anything other than exactly one bit set, and flags them with a sticky error.

---
 rtl/regfile_onehot_wr_pkg.sv | 18 +
 rtl/regfile_onehot_wr_onehot_check.sv | 27 ++
 rtl/regfile_onehot_wr.sv | 105 ++++++++++
 3 files changed

// File: rtl/regfile_onehot_wr_pkg.sv
// Shared definitions for the general-purpose register file and for any
// other consumer of the 6-to-64 write-address decoder's select words.
//   REG_ADDR_W : register address width
//   NREG       : number of registers, which is also the select-word width
//   DATA_W     : register data width
//   REG_ZERO   : address of the hard-wired zero register
//   reg_word_t : one register's worth of data
package regfile_onehot_wr_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int NREG       = 64;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 6'd0;

  typedef logic [DATA_W-1:0] reg_word_t;

endpackage : regfile_onehot_wr_pkg

// File: rtl/regfile_onehot_wr_onehot_check.sv
// Classifies a select word as exactly-one-hot, all-zero, or neither.
// Uses the x & (x-1) identity, which clears the lowest set bit, so no
// popcount adder tree is needed. The result is purely combinational.
//   sel       : input  [N-1:0]  select word under test
//   is_onehot : output          exactly one bit of sel is set
//   is_zero   : output          no bit of sel is set
module regfile_onehot_wr_onehot_check
  import regfile_onehot_wr_pkg::*;
#(
  parameter int N = regfile_onehot_wr_pkg::NREG
) (
  input  logic [N-1:0] sel,
  output logic         is_onehot,
  output logic         is_zero
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] low_cleared;

  // sel with its lowest set bit removed; zero exactly when sel had <= 1 bit.
  assign low_cleared = sel & (sel - ONE);

  assign is_zero   = (sel == '0);
  assign is_onehot = !is_zero && (low_cleared == '0);

endmodule : regfile_onehot_wr_onehot_check

// File: rtl/regfile_onehot_wr.sv
// 64-entry register file for the single-cycle core. Writes are steered by
// the one-hot select word from the upstream address decoder; malformed
// select words are rejected and latched into a sticky error flag. Two
// combinational read ports with no write bypass feed the ALU operand muxes.
//   clk       : input           core clock, rising edge
//   rst       : input           synchronous active-high reset
//   wr_en     : input           write request this cycle
//   wr_sel    : input  [NREG]   one-hot write select, bit k -> register k
//   wr_data   : input  [WIDTH]  write data
//   rd_addr_a : input  [6]      read port A address
//   rd_addr_b : input  [6]      read port B address
//   rd_data_a : output [WIDTH]  read port A data
//   rd_data_b : output [WIDTH]  read port B data
//   sel_err   : output          sticky: malformed select seen while wr_en=1
//   wr_count  : output [16]     accepted-write counter, wraps at 0xFFFF
// NREG must equal the select-word width and fit the 6-bit read address.
module regfile_onehot_wr
  import regfile_onehot_wr_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int NREG    = regfile_onehot_wr_pkg::NREG,
  parameter int ZERO_R0 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [NREG-1:0]       wr_sel,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_a,
  output logic [WIDTH-1:0]      rd_data_b,
  output logic                  sel_err,
  output logic [15:0]           wr_count
);

  localparam bit R0_IS_ZERO = (ZERO_R0 != 0);

  logic [WIDTH-1:0] regs [NREG];

  logic sel_onehot;
  logic sel_zero;
  logic sel_bad;
  logic r0_drop;
  logic wr_accept;

  regfile_onehot_wr_onehot_check #(
    .N (NREG)
  ) u_onehot_check (
    .sel       (wr_sel),
    .is_onehot (sel_onehot),
    .is_zero   (sel_zero)
  );

  // wr_sel is only judged when a write is requested.
  assign sel_bad = wr_en && (sel_zero || !sel_onehot);

  // A legal write to the hard-wired zero register is silently dropped: it
  // neither counts nor raises the error flag.
  assign r0_drop   = R0_IS_ZERO && wr_sel[0];
  assign wr_accept = wr_en && sel_onehot && !r0_drop;

  // NOTE: every register here must be cleared by reset, so the array is
  // built from resettable flops and cannot be mapped onto a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together from pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      sel_err  <= 1'b0;
      wr_count <= '0;
    end else begin
      if (wr_accept) begin
        // wr_sel is known one-hot here, so exactly one register loads.
        for (int i = 0; i < NREG; i++) begin
          if (wr_sel[i]) begin
            regs[i] <= wr_data;
          end
        end
        wr_count <= wr_count + 16'd1;
      end
      if (sel_bad) begin
        sel_err <= 1'b1;
      end
    end
  end

  // Reads see current contents only; a same-cycle write to the address
  // appears after the edge.
  // NOTE: outputs get a default before any condition so no path leaves
  // them unassigned, which would infer a latch.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (R0_IS_ZERO && (rd_addr_a == REG_ZERO)) begin
      rd_data_a = '0;
    end
    if (R0_IS_ZERO && (rd_addr_b == REG_ZERO)) begin
      rd_data_b = '0;
    end
  end

endmodule : regfile_onehot_wr
